// File: rtl/median_filter_ctrl_pkg.sv
// Shared constants and state type for the median_filter sequencer and its datapath.
package median_filter_ctrl_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned DEF_WIDTH = 1080;
    localparam int unsigned DEF_DEPTH = 1080;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StProc,
        StDrain
    } state_e;

endpackage

// File: rtl/median_filter_ctrl_if.sv
// Stream, control and datapath-side signals of the median_filter sequencer.
interface median_filter_ctrl_if;

    logic                                     start;
    logic                                     abort;
    logic                                     busy;
    logic                                     done;
    logic                                     pix_in_valid;
    logic                                     pix_in_ready;
    logic [median_filter_ctrl_pkg::PIX_W-1:0] pix_in_data;
    logic [median_filter_ctrl_pkg::PIX_W-1:0] mf_pixel;
    logic                                     mf_enable;
    logic                                     mf_enable_process;
    logic [median_filter_ctrl_pkg::PIX_W-1:0] mf_result;
    logic                                     pix_out_valid;
    logic [median_filter_ctrl_pkg::PIX_W-1:0] pix_out_data;
    logic                                     pix_out_last;

    modport slave (
        input  start, abort, pix_in_valid, pix_in_data, mf_result,
        output busy, done, pix_in_ready, mf_pixel, mf_enable, mf_enable_process,
               pix_out_valid, pix_out_data, pix_out_last
    );

    modport master (
        output start, abort, pix_in_valid, pix_in_data, mf_result,
        input  busy, done, pix_in_ready, mf_pixel, mf_enable, mf_enable_process,
               pix_out_valid, pix_out_data, pix_out_last
    );

endinterface

// File: rtl/median_filter_ctrl_mf_lat_pipe.sv
// Valid delay line matching the median_filter result latency; clearable on abort.
module mf_lat_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_pipe;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_valid = r_pipe[DEPTH-1];

endmodule

// File: rtl/median_filter_ctrl.sv
// Load / settle / process / drain sequencer around the median_filter datapath.
module median_filter_ctrl
    import median_filter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PROC_LAT      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    median_filter_ctrl_if.slave  bus
);

    localparam int unsigned NPIX = WIDTH * DEPTH;
    localparam int unsigned CW   = $clog2(NPIX + 1);
    localparam int unsigned SW   = $clog2(SETTLE_CYCLES + 1);

    state_e             r_state, w_state_d;
    logic [CW-1:0]      r_load_cnt, w_load_cnt_d;
    logic [CW-1:0]      r_proc_cnt, w_proc_cnt_d;
    logic [CW-1:0]      r_out_cnt, w_out_cnt_d;
    logic [SW-1:0]      r_settle_cnt, w_settle_cnt_d;
    logic               r_busy, w_busy_d;
    logic               r_done, w_done_d;
    logic               r_mf_enable, w_mf_enable_d;
    logic [PIX_W-1:0]   r_mf_pixel, w_mf_pixel_d;
    logic               r_mf_proc, w_mf_proc_d;
    logic               r_pix_out_valid, w_pix_out_valid_d;
    logic [PIX_W-1:0]   r_pix_out_data, w_pix_out_data_d;
    logic               r_pix_out_last, w_pix_out_last_d;
    logic               w_ready;
    logic               w_hs;
    logic               w_lat_valid;

    assign w_ready = (r_state == StLoad);
    assign w_hs    = bus.pix_in_valid & w_ready;

    // Fed with the next-state enable so the tap lines up with mf_result sampling,
    // PROC_LAT edges after the edge that raised mf_enable_process.
    mf_lat_pipe #(
        .DEPTH (PROC_LAT)
    ) u_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (bus.abort),
        .i_valid (w_mf_proc_d),
        .o_valid (w_lat_valid)
    );

    always_comb begin
        w_state_d         = r_state;
        w_load_cnt_d      = r_load_cnt;
        w_proc_cnt_d      = r_proc_cnt;
        w_out_cnt_d       = r_out_cnt;
        w_settle_cnt_d    = r_settle_cnt;
        w_done_d          = 1'b0;
        w_mf_enable_d     = 1'b0;
        w_mf_pixel_d      = r_mf_pixel;
        w_mf_proc_d       = 1'b0;
        w_pix_out_valid_d = w_lat_valid;
        w_pix_out_data_d  = r_pix_out_data;
        w_pix_out_last_d  = 1'b0;

        if (w_lat_valid) begin
            w_pix_out_data_d = bus.mf_result;
            w_pix_out_last_d = (r_out_cnt == CW'(NPIX - 1));
            w_out_cnt_d      = r_out_cnt + CW'(1);
        end

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_d    = StLoad;
                    w_load_cnt_d = '0;
                    w_proc_cnt_d = '0;
                    w_out_cnt_d  = '0;
                end
            end
            StLoad: begin
                if (w_hs) begin
                    w_mf_enable_d = 1'b1;
                    w_mf_pixel_d  = bus.pix_in_data;
                    w_load_cnt_d  = r_load_cnt + CW'(1);
                    if (r_load_cnt == CW'(NPIX - 1)) begin
                        w_state_d      = StSettle;
                        w_settle_cnt_d = '0;
                    end
                end
            end
            StSettle: begin
                if (r_settle_cnt == SW'(SETTLE_CYCLES)) begin
                    w_state_d   = StProc;
                    w_mf_proc_d = 1'b1;
                end else begin
                    w_settle_cnt_d = r_settle_cnt + SW'(1);
                end
            end
            StProc: begin
                w_proc_cnt_d = r_proc_cnt + CW'(1);
                if (r_proc_cnt == CW'(NPIX - 1)) begin
                    w_state_d = StDrain;
                end else begin
                    w_mf_proc_d = 1'b1;
                end
            end
            StDrain: begin
                if (r_out_cnt == CW'(NPIX)) begin
                    w_done_d  = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Abort beats start and drops everything except the data holding registers.
        if (bus.abort) begin
            w_state_d         = StIdle;
            w_load_cnt_d      = '0;
            w_proc_cnt_d      = '0;
            w_out_cnt_d       = '0;
            w_settle_cnt_d    = '0;
            w_done_d          = 1'b0;
            w_mf_enable_d     = 1'b0;
            w_mf_pixel_d      = r_mf_pixel;
            w_mf_proc_d       = 1'b0;
            w_pix_out_valid_d = 1'b0;
            w_pix_out_data_d  = r_pix_out_data;
            w_pix_out_last_d  = 1'b0;
        end

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= StIdle;
            r_load_cnt      <= '0;
            r_proc_cnt      <= '0;
            r_out_cnt       <= '0;
            r_settle_cnt    <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_mf_enable     <= 1'b0;
            r_mf_pixel      <= '0;
            r_mf_proc       <= 1'b0;
            r_pix_out_valid <= 1'b0;
            r_pix_out_data  <= '0;
            r_pix_out_last  <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_load_cnt      <= w_load_cnt_d;
            r_proc_cnt      <= w_proc_cnt_d;
            r_out_cnt       <= w_out_cnt_d;
            r_settle_cnt    <= w_settle_cnt_d;
            r_busy          <= w_busy_d;
            r_done          <= w_done_d;
            r_mf_enable     <= w_mf_enable_d;
            r_mf_pixel      <= w_mf_pixel_d;
            r_mf_proc       <= w_mf_proc_d;
            r_pix_out_valid <= w_pix_out_valid_d;
            r_pix_out_data  <= w_pix_out_data_d;
            r_pix_out_last  <= w_pix_out_last_d;
        end
    end

    assign bus.busy              = r_busy;
    assign bus.done              = r_done;
    assign bus.pix_in_ready      = w_ready;
    assign bus.mf_pixel          = r_mf_pixel;
    assign bus.mf_enable         = r_mf_enable;
    assign bus.mf_enable_process = r_mf_proc;
    assign bus.pix_out_valid     = r_pix_out_valid;
    assign bus.pix_out_data      = r_pix_out_data;
    assign bus.pix_out_last      = r_pix_out_last;

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Runs two controllers (PROC_LAT 1 and 3) in lockstep against a frame-level reference model.
module tb_median_filter_ctrl;

    localparam int W    = 4;
    localparam int D    = 3;
    localparam int NPIX = W * D;
    localparam int SC   = 2;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       ready;
        logic       en;
        logic [7:0] pix;
        logic       proc;
        logic       ov;
        logic [7:0] od;
        logic       last;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    median_filter_ctrl_if b1 ();
    median_filter_ctrl_if b3 ();

    median_filter_ctrl #(
        .WIDTH (W), .DEPTH (D), .SETTLE_CYCLES (SC), .PROC_LAT (1)
    ) u_dut1 (
        .clk (clk), .rst (rst), .bus (b1.slave)
    );

    median_filter_ctrl #(
        .WIDTH (W), .DEPTH (D), .SETTLE_CYCLES (SC), .PROC_LAT (3)
    ) u_dut3 (
        .clk (clk), .rst (rst), .bus (b3.slave)
    );

    assign b3.start        = b1.start;
    assign b3.abort        = b1.abort;
    assign b3.pix_in_valid = b1.pix_in_valid;
    assign b3.pix_in_data  = b1.pix_in_data;

    out_t o [2];
    assign o[0] = {b1.busy, b1.done, b1.pix_in_ready, b1.mf_enable, b1.mf_pixel,
                   b1.mf_enable_process, b1.pix_out_valid, b1.pix_out_data, b1.pix_out_last};
    assign o[1] = {b3.busy, b3.done, b3.pix_in_ready, b3.mf_enable, b3.mf_pixel,
                   b3.mf_enable_process, b3.pix_out_valid, b3.pix_out_data, b3.pix_out_last};

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Datapath model: the result of the k-th process cycle must be present on mf_result
    // PROC_LAT-1 cycles later, so it is sampled PROC_LAT edges after that cycle began.
    logic [7:0] res_tab [NPIX];
    logic [7:0] res_drv [2];
    int         hist [2][4];
    int         pidx [2];

    assign b1.mf_result = res_drv[0];
    assign b3.mf_result = res_drv[1];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!o[d].busy) begin
                pidx[d] = 0;
                for (int i = 0; i < 4; i++) hist[d][i] = -1;
            end
            for (int i = 3; i > 0; i--) hist[d][i] = hist[d][i-1];
            if (o[d].proc) begin
                hist[d][0] = pidx[d];
                pidx[d]++;
            end else begin
                hist[d][0] = -1;
            end
            if (hist[d][lat(d)-1] >= 0 && hist[d][lat(d)-1] < NPIX)
                res_drv[d] = res_tab[hist[d][lat(d)-1]];
            else
                res_drv[d] = 8'($urandom);
        end
    end

    logic [7:0] px_tab [NPIX];

    task automatic run_frame(input bit in_ramp, input bit res_ramp, input bit stall,
                             input bit restart, input int abort_at, input int rst_at);
        int n_en [2]     = '{0, 0};
        int n_proc [2]   = '{0, 0};
        int n_out [2]    = '{0, 0};
        int n_done [2]   = '{0, 0};
        int n_last [2]   = '{0, 0};
        int last_at [2]  = '{-1, -1};
        int n_ovl [2]    = '{0, 0};
        int n_bad [2]    = '{0, 0};
        int c_last_en [2] = '{-1, -1};
        int c_fproc [2]  = '{-1, -1};
        int c_fout [2]   = '{-1, -1};
        int c_done [2]   = '{-1, -1};
        int  idx_drv = 0;
        bit  prev_hs = 1'b0;
        bit  hs;
        bit  did_abort = 1'b0, did_rst = 1'b0, did_restart = 1'b0;
        int  c_abort = -10, c_rst = -10, c_start, tail = -1;
        string pfx;

        for (int i = 0; i < NPIX; i++) begin
            px_tab[i]  = in_ramp ? 8'(i) : 8'($urandom);
            res_tab[i] = res_ramp ? 8'(i) : 8'($urandom);
        end

        @(negedge clk);
        c_start         = cyc;
        b1.start        = 1'b1;
        b1.pix_in_valid = 1'b1;
        b1.pix_in_data  = px_tab[0];

        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            b1.start = 1'b0;
            b1.abort = 1'b0;
            rst      = 1'b0;
            for (int d = 0; d < 2; d++) begin
                pfx = $sformatf("lat%0d_", lat(d));
                if (o[d].en) begin
                    if (n_en[d] < NPIX) chk({pfx, "load_pix"}, o[d].pix, px_tab[n_en[d]]);
                    n_en[d]++;
                    c_last_en[d] = cyc;
                end
                if (o[d].en !== prev_hs) n_bad[d]++;
                if (o[d].en && o[d].proc) n_ovl[d]++;
                if (o[d].proc) begin
                    if (n_proc[d] == 0) c_fproc[d] = cyc;
                    n_proc[d]++;
                end
                if (o[d].ov) begin
                    if (n_out[d] == 0) c_fout[d] = cyc;
                    if (n_out[d] < NPIX) chk({pfx, "out_data"}, o[d].od, res_tab[n_out[d]]);
                    n_out[d]++;
                    if (o[d].last) begin
                        n_last[d]++;
                        last_at[d] = n_out[d];
                    end
                end else if (o[d].last) begin
                    n_last[d]++;
                end
                if (o[d].done) begin
                    n_done[d]++;
                    c_done[d] = cyc;
                    chk({pfx, "busy_at_done"}, o[d].busy, 0);
                end
                if (did_abort && cyc == c_abort + 1) begin
                    chk({pfx, "abort_busy"}, o[d].busy, 0);
                    chk({pfx, "abort_proc"}, o[d].proc, 0);
                end
                if (did_rst && cyc == c_rst + 1) begin
                    chk({pfx, "rst_outs"}, o[d], 0);
                    chk({pfx, "rst_ready"}, o[d].ready, 0);
                end
            end

            hs = 1'b1;
            if (rst_at > 0 && !did_rst && idx_drv == rst_at) begin
                rst = 1'b1; did_rst = 1'b1; c_rst = cyc; hs = 1'b0;
            end
            if (abort_at > 0 && !did_abort && n_proc[0] == abort_at) begin
                b1.abort = 1'b1; did_abort = 1'b1; c_abort = cyc; hs = 1'b0;
            end
            if (restart && !did_restart && o[0].proc && n_proc[0] == 3) begin
                b1.start = 1'b1; did_restart = 1'b1;
            end
            b1.pix_in_valid = stall ? (cyc % 2 == 1) : 1'b1;
            b1.pix_in_data  = (idx_drv < NPIX) ? px_tab[idx_drv] : 8'($urandom);
            hs = hs && b1.pix_in_valid && o[0].ready;
            if (hs) idx_drv++;
            prev_hs = hs;

            if (tail < 0 && ((n_done[0] > 0 && n_done[1] > 0) || did_abort || did_rst))
                tail = 0;
            else if (tail >= 0)
                tail++;
            if (tail == 8) break;
        end
        b1.pix_in_valid = 1'b0;

        for (int d = 0; d < 2; d++) begin
            pfx = $sformatf("lat%0d_", lat(d));
            chk({pfx, "no_overlap"}, n_ovl[d], 0);
            chk({pfx, "en_follows_hs"}, n_bad[d], 0);
            if (did_rst) begin
                chk({pfx, "rst_loads"}, n_en[d], rst_at);
                chk({pfx, "rst_no_done"}, n_done[d], 0);
            end else if (did_abort) begin
                chk({pfx, "abort_proc_cnt"}, n_proc[d], abort_at);
                chk({pfx, "abort_out_cnt"}, n_out[d], abort_at - lat(d));
                chk({pfx, "abort_no_done"}, n_done[d], 0);
            end else begin
                chk({pfx, "load_cnt"}, n_en[d], NPIX);
                chk({pfx, "proc_cnt"}, n_proc[d], NPIX);
                chk({pfx, "out_cnt"}, n_out[d], NPIX);
                chk({pfx, "done_cnt"}, n_done[d], 1);
                chk({pfx, "last_cnt"}, n_last[d], 1);
                chk({pfx, "last_pos"}, last_at[d], NPIX);
                chk({pfx, "settle_gap"}, c_fproc[d] - c_last_en[d], SC + 1);
                chk({pfx, "first_out_lat"}, c_fout[d] - c_last_en[d], SC + lat(d) + 1);
                chk({pfx, "proc_to_out"}, c_fout[d] - c_fproc[d], lat(d));
                if (!stall)
                    chk({pfx, "start_to_done"}, c_done[d] - c_start + 1,
                        2 * NPIX + SC + lat(d) + 3);
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        b1.start        = 1'b0;
        b1.abort        = 1'b0;
        b1.pix_in_valid = 1'b0;
        b1.pix_in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outs_lat1", o[0], 0);
        chk("reset_outs_lat3", o[1], 0);
        rst = 1'b0;

        // abort wins over start while idle
        @(negedge clk);
        b1.start = 1'b1;
        b1.abort = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        b1.abort = 1'b0;
        chk("abort_over_start_lat1", o[0].busy, 0);
        chk("abort_over_start_lat3", o[1].busy, 0);

        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);  // ramp 0..11, no stalls
        run_frame(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);  // stall every other cycle
        run_frame(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);  // start during PROC
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 5, 0);  // abort on 5th PROC cycle
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0, 6);  // reset after 6 loads
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        run_frame(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);  // mf_result = process index

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
